dp_accum8: RTL and testbench
============================

Name: dp_accum8

Overview:
- 8-bit accumulator datapath that executes the control words issued by the team's 3-bit-opcode control unit, and returns the opcode and accumulator status flags to it.
- Contains the PC, IR, accumulator A, ALU and a 32x8 unified program/data RAM with a synchronous read.
- A side-band program-load port fills the RAM before the CPU is released.

Parameters:
DW, 8, data/accumulator width
AW, 5, address width; RAM depth is 2**AW

Ports:
Clock  in  1  system clock; all state updates on its rising edge
Reset  in  1  asynchronous, active-low reset
IRload  in  1  load IR from RAM read data
JMPmux  in  1  PC next-value select: 0 = PC+1, 1 = IR[AW-1:0]
PCload  in  1  PC load enable
Meminst  in  1  RAM address select: 0 = PC, 1 = IR[AW-1:0]
MemWr  in  1  RAM write strobe; writes A
Asel  in  2  A source: 00 = ALU, 01 = Input, 10 = RAM data, 11 = hold A
Aload  in  1  A load enable
Sub  in  1  ALU op: 0 = A+M, 1 = A-M
Input  in  DW  external input value
ProgWr  in  1  program-load write strobe
ProgAddr  in  AW  program-load address
ProgData  in  DW  program-load data
IR  out  3  opcode, IRreg[7:5]
Aeq0  out  1  A == 0
Apos  out  1  ~A[DW-1], i.e. A >= 0 in two's complement
Output  out  DW  A register
PCout  out  AW  PC, for debug

Behaviour:
- Reset (Reset low, asynchronous): PC=0, IRreg=0, A=0, RAM read register Mq=0. RAM array contents are not cleared.
- Outputs after reset: IR=000, Aeq0=1, Apos=1, Output=0, PCout=0.
- Instruction word format: [7:5] opcode, [4:0] operand address.
- RAM address: addr = Meminst ? IRreg[4:0] : PC.
- RAM read: synchronous. Every edge, Mq <= mem[addr]. Read data therefore lags the address by one cycle; this matches the control sequence start→fetch and decode→load/add/sub.
- Read during write: Mq returns the old contents.
- RAM write: on the edge where MemWr=1, mem[addr] <= A.
- Program load: ProgWr=1 writes mem[ProgAddr] <= ProgData. ProgWr has priority over MemWr when both are asserted in the same cycle; the MemWr write is dropped. ProgAddr does not affect Mq.
- IR: on IRload, IRreg <= Mq.
- PC: on PCload, PC <= JMPmux ? IRreg[4:0] : PC+1.
  - PC+1 wraps modulo 32 (31 → 0).
  - Jump target uses IRreg as it stands before the edge.
- ALU: combinational, result = Sub ? A - Mq : A + Mq, modulo 2**DW. No carry or overflow flags.
- A: on Aload, loads the mux selected by Asel. Asel=11 keeps A unchanged.
- Aload=0 holds A regardless of Asel.
- Simultaneous enables: IRload, PCload and Aload act independently in the same edge; every right-hand side uses pre-edge values.
- Flags: combinational from A.
- Halt is not an input: the datapath is idle whenever all enables are 0.
- Reset mid-operation: registers clear immediately. Any RAM write on a concurrent edge is suppressed while Reset is low.

Decomposition:
- Shared package dp_pkg:
  - DW and AW.
  - Opcode constants OP_LOAD=000, OP_STORE=001, OP_ADD=010, OP_SUB=011, OP_IN=100, OP_JZ=101, OP_JPOS=110, OP_HALT=111.
  - Asel codes ASEL_ALU=00, ASEL_IN=01, ASEL_MEM=10, ASEL_HOLD=11.
- One sub-module: ram_sync (parameterised AW/DW, one write port, registered read, write-arbitration mux outside).
- PC, IR, A and the ALU stay in the top level.

Test Plan:
- Reset: drive registers non-zero, pull Reset low between edges → PC=0, IR=000, Output=0, Aeq0=1, Apos=1 before the next edge. RAM mem[3]=0x55 is preserved.
- Fetch: ProgWr mem[0]=0x83. Release reset, one cycle idle, then IRload=PCload=1 → IRreg=0x83, IR=100, PCout=1.
- Input and flags:
  - Input=0x05, Asel=01, Aload=1 → Output=0x05, Aeq0=0, Apos=1.
  - Input=0x80 → Apos=0.
  - Input=0x00 → Aeq0=1.
- Add/sub: mem[10]=0x07, IRreg addr=10. Meminst=1 for one cycle, then Aload, Asel=00:
  - Sub=0 with A=0x05 → 0x0C.
  - Sub=1 with A=0x05 → 0xFE, Apos=0.
  - A=0xFF + 0x01 → 0x00, Aeq0=1.
- Store/priority:
  - A=0x3C, Meminst=1, MemWr=1 at addr 12 → readback 0x3C.
  - Same edge as ProgWr to addr 12 with 0x99 → mem[12]=0x99.
- Jump/wrap:
  - IRreg=0xB9, JMPmux=1, PCload=1 → PCout=25.
  - From PC=31, JMPmux=0, PCload=1 → PCout=0.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared widths, opcode and A-source encodings for the 8-bit accumulator datapath.
package dp_pkg;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_IN    = 3'b100,
    OP_JZ    = 3'b101,
    OP_JPOS  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ASEL_ALU  = 2'b00,
    ASEL_IN   = 2'b01,
    ASEL_MEM  = 2'b10,
    ASEL_HOLD = 2'b11
  } asel_e;

endpackage

// File: rtl/ram_sync.sv
// Single write port RAM with a registered read; read during write returns old contents.
module ram_sync #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] rdata_q;

  // Array is never cleared; writes are blocked while reset is held.
  always_ff @(posedge clk_i) begin
    if (we_i && rst_ni) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dp_accum8.sv
// Accumulator datapath: PC, IR, A, add/sub ALU and unified program/data RAM.
module dp_accum8
  import dp_pkg::*;
#(
  parameter int unsigned DW = dp_pkg::DW,
  parameter int unsigned AW = dp_pkg::AW
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          IRload,
  input  logic          JMPmux,
  input  logic          PCload,
  input  logic          Meminst,
  input  logic          MemWr,
  input  logic [1:0]    Asel,
  input  logic          Aload,
  input  logic          Sub,
  input  logic [DW-1:0] Input,
  input  logic          ProgWr,
  input  logic [AW-1:0] ProgAddr,
  input  logic [DW-1:0] ProgData,
  output logic [2:0]    IR,
  output logic          Aeq0,
  output logic          Apos,
  output logic [DW-1:0] Output,
  output logic [AW-1:0] PCout
);

  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] mq;
  logic [DW-1:0] alu_res;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;

  // Program load wins the write port; the read side always follows the CPU address.
  always_comb begin
    ram_addr  = Meminst ? ir_q[AW-1:0] : pc_q;
    ram_we    = ProgWr | MemWr;
    ram_waddr = ProgWr ? ProgAddr : ram_addr;
    ram_wdata = ProgWr ? ProgData : a_q;
  end

  ram_sync #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk_i  (Clock),
    .rst_ni (Reset),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(ram_addr),
    .rdata_o(mq)
  );

  always_comb begin
    alu_res = Sub ? (a_q - mq) : (a_q + mq);
  end

  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    a_d  = a_q;
    if (PCload) begin
      pc_d = JMPmux ? ir_q[AW-1:0] : pc_q + AW'(1);
    end
    if (IRload) begin
      ir_d = mq;
    end
    if (Aload) begin
      unique case (asel_e'(Asel))
        ASEL_ALU:  a_d = alu_res;
        ASEL_IN:   a_d = Input;
        ASEL_MEM:  a_d = mq;
        ASEL_HOLD: a_d = a_q;
        default:   a_d = a_q;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q <= '0;
      ir_q <= '0;
      a_q  <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q  <= a_d;
    end
  end

  assign IR     = ir_q[DW-1 -: 3];
  assign Aeq0   = (a_q == '0);
  assign Apos   = ~a_q[DW-1];
  assign Output = a_q;
  assign PCout  = pc_q;

endmodule

// File: tb/tb_dp_accum8.sv
// Directed bench for dp_accum8 with hand-computed expectations.
module tb_dp_accum8;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, ProgWr;
  logic [1:0] Asel;
  logic [7:0] Input, ProgData;
  logic [4:0] ProgAddr;
  logic [2:0] IR;
  logic       Aeq0, Apos;
  logic [7:0] Output;
  logic [4:0] PCout;

  int n_tests = 0;
  int n_fail  = 0;

  dp_accum8 dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .IRload  (IRload),
    .JMPmux  (JMPmux),
    .PCload  (PCload),
    .Meminst (Meminst),
    .MemWr   (MemWr),
    .Asel    (Asel),
    .Aload   (Aload),
    .Sub     (Sub),
    .Input   (Input),
    .ProgWr  (ProgWr),
    .ProgAddr(ProgAddr),
    .ProgData(ProgData),
    .IR      (IR),
    .Aeq0    (Aeq0),
    .Apos    (Apos),
    .Output  (Output),
    .PCout   (PCout)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_ctl();
    IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0;
    Asel = 2'b11; Aload = 0; Sub = 0; ProgWr = 0;
  endtask

  task automatic prog(input logic [4:0] addr, input logic [7:0] data);
    ProgWr = 1; ProgAddr = addr; ProgData = data;
    step();
    ProgWr = 0;
  endtask

  task automatic load_in(input logic [7:0] val);
    Asel = 2'b01; Aload = 1; Input = val;
    step();
    Aload = 0;
  endtask

  initial begin
    Reset = 0; Input = 0; ProgAddr = 0; ProgData = 0;
    idle_ctl();
    step(); step();
    check_eq("rst_ir", 32'(IR), 32'h0);
    check_eq("rst_aeq0", 32'(Aeq0), 32'h1);
    check_eq("rst_apos", 32'(Apos), 32'h1);
    check_eq("rst_out", 32'(Output), 32'h0);
    check_eq("rst_pc", 32'(PCout), 32'h0);

    Reset = 1;
    prog(5'd0, 8'h83);
    prog(5'd1, 8'h4A);
    prog(5'd2, 8'h2C);
    prog(5'd3, 8'h55);
    prog(5'd10, 8'h07);

    // Fetch
    step();
    IRload = 1; PCload = 1; step(); idle_ctl();
    check_eq("fetch_ir", 32'(IR), 32'h4);
    check_eq("fetch_pc", 32'(PCout), 32'd1);

    // Input and flags
    load_in(8'h05);
    check_eq("in5_out", 32'(Output), 32'h05);
    check_eq("in5_aeq0", 32'(Aeq0), 32'h0);
    check_eq("in5_apos", 32'(Apos), 32'h1);
    load_in(8'h80);
    check_eq("in80_apos", 32'(Apos), 32'h0);
    load_in(8'h00);
    check_eq("in0_aeq0", 32'(Aeq0), 32'h1);
    load_in(8'h05);

    // Add/sub with operand mem[10]
    IRload = 1; step(); idle_ctl();
    check_eq("ir_add", 32'(IR), 32'h2);
    Meminst = 1; step();
    Asel = 2'b00; Aload = 1; Sub = 0; step();
    check_eq("add_5p7", 32'(Output), 32'h0C);
    Aload = 0; load_in(8'h05);
    Asel = 2'b00; Aload = 1; Sub = 1; step(); Aload = 0; Sub = 0;
    check_eq("sub_5m7", 32'(Output), 32'hFE);
    check_eq("sub_apos", 32'(Apos), 32'h0);
    // Overwrite mem[10] while it is being read: read data lags with old value
    ProgWr = 1; ProgAddr = 5'd10; ProgData = 8'h01;
    Asel = 2'b01; Aload = 1; Input = 8'hFF; step();
    ProgWr = 0; Asel = 2'b00; step(); Aload = 0;
    check_eq("rdw_old", 32'(Output), 32'h06);
    load_in(8'hFF);
    Asel = 2'b00; Aload = 1; step(); Aload = 0;
    check_eq("add_wrap", 32'(Output), 32'h00);
    check_eq("wrap_aeq0", 32'(Aeq0), 32'h1);

    // Store and write priority at mem[12]
    idle_ctl();
    PCload = 1; step(); idle_ctl();
    load_in(8'h3C);
    IRload = 1; step(); idle_ctl();
    check_eq("ir_store", 32'(IR), 32'h1);
    Meminst = 1; MemWr = 1; step(); MemWr = 0;
    load_in(8'h00);
    Asel = 2'b10; Aload = 1; step(); Aload = 0;
    check_eq("store_rb", 32'(Output), 32'h3C);
    MemWr = 1; ProgWr = 1; ProgAddr = 5'd12; ProgData = 8'h99; step();
    MemWr = 0; ProgWr = 0; step();
    Asel = 2'b10; Aload = 1; step(); Aload = 0;
    check_eq("prog_prio", 32'(Output), 32'h99);

    // Jumps use the pre-edge IR
    prog(5'd12, 8'hB9);
    step();
    IRload = 1; PCload = 1; JMPmux = 1; step(); IRload = 0; PCload = 0;
    check_eq("jmp_old_ir", 32'(PCout), 32'd12);
    check_eq("ir_jz", 32'(IR), 32'h5);
    PCload = 1; step(); PCload = 0;
    check_eq("jmp_25", 32'(PCout), 32'd25);
    prog(5'd25, 8'hFF);
    step();
    IRload = 1; step(); IRload = 0;
    PCload = 1; JMPmux = 1; step();
    check_eq("jmp_31", 32'(PCout), 32'd31);
    JMPmux = 0; step();
    check_eq("pc_wrap", 32'(PCout), 32'd0);
    step(); idle_ctl();

    // Asynchronous reset between edges; concurrent writes must be suppressed
    #3;
    Reset = 0; ProgWr = 1; ProgAddr = 5'd3; ProgData = 8'hAA;
    Meminst = 1; MemWr = 1;
    #1;
    check_eq("arst_pc", 32'(PCout), 32'd0);
    check_eq("arst_ir", 32'(IR), 32'h0);
    check_eq("arst_out", 32'(Output), 32'h0);
    check_eq("arst_aeq0", 32'(Aeq0), 32'h1);
    check_eq("arst_apos", 32'(Apos), 32'h1);
    step(); step();
    idle_ctl();
    Reset = 1;
    step();
    IRload = 1; step(); IRload = 0;
    Meminst = 1; step();
    Asel = 2'b10; Aload = 1; step(); idle_ctl();
    check_eq("mem3_kept", 32'(Output), 32'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
